// File: rtl/test_monitor_if.sv
// test_monitor_if: register-file write-back bus observed by the end-of-test monitor
interface test_monitor_if #(
    parameter int XLEN = 64
);
    logic            wb_en_i;
    logic [4:0]      wb_addr_i;
    logic [XLEN-1:0] wb_data_i;
    modport master (output wb_en_i, wb_addr_i, wb_data_i);
    modport slave  (input  wb_en_i, wb_addr_i, wb_data_i);
endinterface

// File: rtl/test_monitor.sv
// test_monitor: shadows x3/x26/x27 from write-back and freezes a PASS/FAIL/TIMEOUT verdict
module test_monitor #(
    parameter int XLEN           = 64,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TESTNUM_REG    = 3,
    parameter int DONE_REG       = 26,
    parameter int RESULT_REG     = 27
) (
    input  logic             clk,
    input  logic             rst,
    test_monitor_if.slave    wb,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             done_pulse_o,
    output logic [31:0]      testnum_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);
    typedef enum logic [1:0] {RUN = 2'd0, PASS = 2'd1, FAIL = 2'd2, TIMEOUT = 2'd3} state_t;
    state_t            state, next;
    logic [31:0]       x3_sh;
    logic [XLEN-1:0]   x26_sh, x27_sh;
    logic [CNT_W-1:0]  cnt;
    logic              run, wr, end_hit, to_hit;
    assign run     = state == RUN;
    assign wr      = run && wb.wb_en_i && wb.wb_addr_i != 5'd0;
    assign end_hit = x26_sh == XLEN'(1);
    assign to_hit  = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // State register; terminal states hold until reset
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= next;
    end
    // Verdict: a completed end check beats a coincident watchdog expiry
    always_comb begin
        next = state;
        if (run) next = end_hit ? (x27_sh == XLEN'(1) ? PASS : FAIL) : (to_hit ? TIMEOUT : RUN);
    end
    // Shadows and counter track only while running, so the verdict context freezes
    always_ff @(posedge clk) begin
        if (rst) begin
            x3_sh        <= '0;
            x26_sh       <= '0;
            x27_sh       <= '0;
            cnt          <= '0;
            done_pulse_o <= 1'b0;
        end else begin
            done_pulse_o <= run && next != RUN;
            if (run) begin
                if (wr && wb.wb_addr_i == 5'(TESTNUM_REG)) x3_sh  <= wb.wb_data_i[31:0];
                if (wr && wb.wb_addr_i == 5'(DONE_REG))    x26_sh <= wb.wb_data_i;
                if (wr && wb.wb_addr_i == 5'(RESULT_REG))  x27_sh <= wb.wb_data_i;
                cnt <= &cnt ? cnt : cnt + 1'b1;
            end
        end
    end
    assign done_o      = state != RUN;
    assign pass_o      = state == PASS;
    assign fail_o      = state == FAIL;
    assign timeout_o   = state == TIMEOUT;
    assign testnum_o   = x3_sh;
    assign cycle_cnt_o = cnt;
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed vectors against test_monitor with a short watchdog
module tb_test_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done_o, pass_o, fail_o, timeout_o, done_pulse_o;
    logic [31:0] testnum_o, cycle_cnt_o;
    int          vecs = 0;
    int          errs = 0;
    test_monitor_if #(.XLEN(64)) bus ();
    test_monitor #(.XLEN(64), .CNT_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .wb(bus),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .done_pulse_o(done_pulse_o), .testnum_o(testnum_o), .cycle_cnt_o(cycle_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] addr, input logic [63:0] data, input logic en = 1'b1);
        bus.wb_en_i   = en;
        bus.wb_addr_i = addr;
        bus.wb_data_i = data;
        tick();
        bus.wb_en_i   = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.wb_en_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {59'd0, done_o, pass_o, fail_o, timeout_o, done_pulse_o}, {59'd0, exp});
    endtask
    initial begin
        bus.wb_en_i   = 1'b0;
        bus.wb_addr_i = 5'd0;
        bus.wb_data_i = 64'd0;
        tick();
        // reset state
        do_reset();
        chk_flags("rst_flags", 5'b00000);
        chk("rst_cnt", cycle_cnt_o, 64'd0);
        chk("rst_tnum", testnum_o, 64'd0);
        // 1: PASS with testnum 5, pulse on the edge after the x26 write
        wr(5'd3, 64'd5);
        wr(5'd27, 64'd1);
        wr(5'd26, 64'd1);
        chk_flags("t1_not_yet", 5'b00000);
        tick();
        chk_flags("t1_pass", 5'b11001);
        chk("t1_tnum", testnum_o, 64'd5);
        chk("t1_cnt", cycle_cnt_o, 64'd4);
        tick();
        chk_flags("t1_pulse_drop", 5'b11000);
        chk("t1_cnt_frozen", cycle_cnt_o, 64'd4);
        // 2: FAIL with testnum 7; later writes cannot change it
        do_reset();
        wr(5'd3, 64'd7);
        wr(5'd27, 64'd0);
        wr(5'd26, 64'd1);
        tick();
        chk_flags("t2_fail", 5'b10101);
        chk("t2_tnum", testnum_o, 64'd7);
        wr(5'd27, 64'd1);
        wr(5'd3, 64'd9);
        tick();
        chk_flags("t2_sticky", 5'b10100);
        chk("t2_tnum_frozen", testnum_o, 64'd7);
        // 3a: watchdog expires on edge 16 with count frozen at 16
        do_reset();
        repeat (15) tick();
        chk_flags("t3_before_to", 5'b00000);
        chk("t3_cnt15", cycle_cnt_o, 64'd15);
        tick();
        chk_flags("t3_timeout", 5'b10011);
        chk("t3_cnt16", cycle_cnt_o, 64'd16);
        repeat (3) tick();
        chk("t3_cnt_frozen", cycle_cnt_o, 64'd16);
        chk_flags("t3_sticky", 5'b10010);
        // 3b: end check coinciding with the watchdog wins
        do_reset();
        wr(5'd27, 64'd1);
        repeat (13) tick();
        wr(5'd26, 64'd1);
        chk_flags("t3b_before", 5'b00000);
        tick();
        chk_flags("t3b_pass_wins", 5'b11001);
        chk("t3b_cnt", cycle_cnt_o, 64'd16);
        // 4: only an x26 value of exactly 1 ends the test; x0 and disabled writes ignored
        do_reset();
        wr(5'd26, 64'd2);
        tick();
        chk_flags("t4_x26_2", 5'b00000);
        wr(5'd26, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk_flags("t4_x26_ones", 5'b00000);
        wr(5'd0, 64'd1);
        wr(5'd26, 64'd1, 1'b0);
        tick();
        chk_flags("t4_x0_en0", 5'b00000);
        wr(5'd27, 64'd1);
        wr(5'd26, 64'd1);
        tick();
        chk_flags("t4_pass", 5'b11001);
        // 5: reset two cycles after PASS, then a fresh FAIL run
        do_reset();
        wr(5'd3, 64'd4);
        wr(5'd27, 64'd1);
        wr(5'd26, 64'd1);
        tick();
        chk_flags("t5_pass", 5'b11001);
        repeat (2) tick();
        do_reset();
        chk_flags("t5_rst_flags", 5'b00000);
        chk("t5_rst_cnt", cycle_cnt_o, 64'd0);
        chk("t5_rst_tnum", testnum_o, 64'd0);
        wr(5'd27, 64'd0);
        wr(5'd26, 64'd1);
        tick();
        chk_flags("t5_fail", 5'b10101);
        chk("t5_cnt", cycle_cnt_o, 64'd3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
